multi_mode_ff_bank: RTL and testbench
=====================================

// Module: multi_mode_ff_bank
// PURPOSE
//  - WIDTH-channel bank of configurable flip-flops; one registered mode selects SR, JK, D or T for all channels.
//  - Successor to the single-bit SR flip-flop. Same channel inputs, plus clock enable, registered mode load,
//    deterministic handling of illegal SR inputs, sticky per-channel error flags and a saturating illegal-event counter.
//  - Used as a generic state-bit register bank by control logic in the flip-flop/latch library.
// PARAMETERS
//  - WIDTH     8     number of flip-flop channels (>=1)
//  - CNT_W     8     width of illegal-event counter (>=1)
//  - RST_VAL   '0    WIDTH-bit reset value of q
// PORTS
//  - clk       in   1      rising-edge clock
//  - rst       in   1      synchronous reset, active-high
//  - ce        in   1      clock enable for q update
//  - mode_ld   in   1      load mode register from mode_in
//  - mode_in   in   2      00=SR 01=JK 10=D 11=T
//  - a         in   WIDTH  S / J / D / T input per channel
//  - b         in   WIDTH  R / K input per channel (ignored in D, T)
//  - err_clr   in   1      clear err flags and counter
//  - q         out  WIDTH  registered state
//  - q_bar     out  WIDTH  ~q (combinational)
//  - mode      out  2      current registered mode
//  - err       out  WIDTH  sticky per-channel illegal-SR flag
//  - err_cnt   out  CNT_W  saturating count of cycles with >=1 illegal channel
// BEHAVIOUR
//  - Reset (rst=1 at posedge): q=RST_VAL, mode=2'b10 (D), err=0, err_cnt=0. Reset overrides every other input.
//  - Mode register: mode_ld=1 loads mode_in at the edge. The load takes effect in the NEXT cycle.
//    A q update in the same cycle uses the old mode.
//  - q update: zero latency, only when ce=1. ce=0 holds all q bits, whatever a/b.
//  - SR per channel: {a,b} 00 hold, 01 ->0, 10 ->1, 11 hold (never X) and illegal.
//  - JK per channel: 00 hold, 01 ->0, 10 ->1, 11 toggle.
//  - D per channel: q<=a. b is ignored.
//  - T per channel: a=1 toggles, a=0 holds.
//  - Illegal = mode==SR && ce && a[i]&b[i]. Evaluated only when ce=1.
//  - err[i] is set on illegal and held until err_clr or rst.
//  - err_cnt += 1 on each cycle where any channel is illegal. Saturates at 2**CNT_W-1 (no wrap).
//  - err_clr together with a new illegal event in the same cycle: set wins.
//    err[i] = that cycle's illegal bits, err_cnt = 1. err_clr alone clears err and err_cnt to 0.
//  - Reset mid-operation discards any pending mode_ld. After reset, mode is D.
// CONFIGURATION
//  - Macro MULTI_MODE_FF_BANK_EDGE_DET_EN.
//  - Defined: adds outputs q_rise[WIDTH] and q_fall[WIDTH], both registered.
//    Each is a one-cycle pulse in the cycle after q[i] goes 0->1 (q_rise) or 1->0 (q_fall).
//    Both are 0 during reset and in the first cycle after reset.
//    A reset-caused change of q does not generate a pulse.
//  - Undefined: the ports are absent and no edge-detect flops are built.
// STRUCTURE
//  - Package multi_mode_ff_pkg holds:
//    - typedef enum logic [1:0] ff_mode_t {FF_SR, FF_JK, FF_D, FF_T};
//    - constant FF_MODE_RST = FF_D.
//  - Sub-module ff_cell: one channel's next-state mux plus q register and illegal output.
//    Instanced WIDTH times in a generate loop.
//  - Top level holds the mode register, err/err_cnt logic and the optional edge detect.
// TESTING
//  - Reset: rst=1 with RST_VAL=8'hA5, a=b=FF -> q=A5, mode=D, err=0, err_cnt=0. q_bar=5A.
//  - SR: mode_ld SR, then ce=1 with a=8'h0F, b=8'hF0 -> q=0F.
//    Next cycle a=b=8'h01 -> q bit0 holds, err=01, err_cnt=1.
//  - Counter: CNT_W=2, four consecutive illegal cycles -> err_cnt=3 (saturated).
//    Then err_clr with an illegal event -> err_cnt=1. err_clr alone -> 0.
//  - JK/T: JK mode with a=b=FF over 2 cycles -> q toggles each cycle.
//    T mode with a=8'h81 -> only bits 7 and 0 toggle. No err in either mode.
//  - Mode timing and ce: mode_ld=1 (mode_in=T) with ce=1, a=8'h3C in D mode -> q=3C (old mode applies).
//    Next cycle ce=0, a=FF -> q holds 3C.
//  - Edge detect (macro on): q bit2 0->1 -> q_rise[2]=1 for exactly one cycle, one cycle later.
//    rst asserted -> no pulses.

Source files
------------

// File: rtl/multi_mode_ff_pkg.sv
// Shared types for the multi-mode flip-flop bank: the flip-flop mode
// encoding and the mode the bank wakes up in after reset.
package multi_mode_ff_pkg;

   typedef enum logic [1:0] {
      FF_SR = 2'b00,
      FF_JK = 2'b01,
      FF_D  = 2'b10,
      FF_T  = 2'b11
   } ff_mode_t;

   localparam ff_mode_t FF_MODE_RST = FF_D;

endpackage

// File: rtl/ff_cell.sv
// One channel of the flip-flop bank: next-state selection for SR/JK/D/T,
// the state register, and the illegal-SR indication for this channel.
module ff_cell
   import multi_mode_ff_pkg::*;
#(
   parameter logic RST_BIT = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     ce,
   input  ff_mode_t mode,
   input  logic     a,
   input  logic     b,
   output logic     q,
   output logic     illegal
);

   logic q_next;

   // S=R=1 is only meaningful as an error in SR mode, and only when the
   // register is actually being clocked.
   assign illegal = (mode == FF_SR) && ce && a && b;

   // Next-state selection; SR with both inputs high deliberately holds.
   always_comb begin
      q_next = q;
      case (mode)
         FF_SR: begin
            case ({a, b})
               2'b01:   q_next = 1'b0;
               2'b10:   q_next = 1'b1;
               default: q_next = q;
            endcase
         end
         FF_JK: begin
            case ({a, b})
               2'b01:   q_next = 1'b0;
               2'b10:   q_next = 1'b1;
               2'b11:   q_next = ~q;
               default: q_next = q;
            endcase
         end
         FF_D:    q_next = a;
         FF_T:    q_next = a ? ~q : q;
         default: q_next = q;
      endcase
   end

   // State register, updated only when clock-enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_BIT;
      end else if (ce) begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-channel bank of configurable flip-flops sharing one registered mode.
// Tracks illegal SR input combinations with sticky per-channel flags and a
// saturating event counter.
// Optional: define MULTI_MODE_FF_BANK_EDGE_DET_EN to add registered
// per-channel rise/fall pulse outputs (q_rise, q_fall).
module multi_mode_ff_bank
   import multi_mode_ff_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               CNT_W   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             mode_ld,
   input  logic [1:0]       mode_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] err,
   output logic [CNT_W-1:0] err_cnt
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
   ,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ff_mode_t         mode_reg;
   logic [WIDTH-1:0] illegal;
   logic [WIDTH-1:0] err_reg;
   logic [CNT_W-1:0] err_cnt_reg;
   logic             any_illegal;

   // Mode register: a load becomes visible to the cells on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= FF_MODE_RST;
      end else if (mode_ld) begin
         mode_reg <= ff_mode_t'(mode_in);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         ff_cell #(
            .RST_BIT (RST_VAL[gi])
         ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .mode    (mode_reg),
            .a       (a[gi]),
            .b       (b[gi]),
            .q       (q[gi]),
            .illegal (illegal[gi])
         );
      end
   endgenerate

   assign any_illegal = |illegal;

   // Sticky error flags and saturating counter; a new illegal event beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg     <= '0;
         err_cnt_reg <= '0;
      end else if (err_clr) begin
         err_reg     <= illegal;
         err_cnt_reg <= any_illegal ? CNT_ONE : '0;
      end else begin
         err_reg <= err_reg | illegal;
         if (any_illegal && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_reg <= err_cnt_reg + CNT_ONE;
         end
      end
   end

   assign q_bar   = ~q;
   assign mode    = mode_reg;
   assign err     = err_reg;
   assign err_cnt = err_cnt_reg;

`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
   logic [WIDTH-1:0] q_d_reg;
   logic [WIDTH-1:0] q_rise_reg;
   logic [WIDTH-1:0] q_fall_reg;

   // Edge pulses compare q against its previous value; q_d tracks the reset
   // value during reset so a reset-induced change never produces a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_d_reg    <= RST_VAL;
         q_rise_reg <= '0;
         q_fall_reg <= '0;
      end else begin
         q_d_reg    <= q;
         q_rise_reg <= q & ~q_d_reg;
         q_fall_reg <= ~q & q_d_reg;
      end
   end

   assign q_rise = q_rise_reg;
   assign q_fall = q_fall_reg;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed testbench for multi_mode_ff_bank. Two instances share stimulus:
// dut0 (CNT_W=8, RST_VAL=A5) for function checks, dut1 (CNT_W=2) for
// counter saturation.
module tb_multi_mode_ff_bank;

   logic       clk = 1'b0;
   logic       rst, ce, mode_ld, err_clr;
   logic [1:0] mode_in;
   logic [7:0] a, b;

   logic [7:0] q0, qb0, err0, cnt0;
   logic [1:0] mode0;
   logic [7:0] q1, qb1, err1;
   logic [1:0] mode1, cnt1;
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
   logic [7:0] rise0, fall0, rise1, fall1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_mode_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'hA5)) dut0 (
      .clk(clk), .rst(rst), .ce(ce), .mode_ld(mode_ld), .mode_in(mode_in),
      .a(a), .b(b), .err_clr(err_clr), .q(q0), .q_bar(qb0), .mode(mode0),
      .err(err0), .err_cnt(cnt0)
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      , .q_rise(rise0), .q_fall(fall0)
`endif
   );

   multi_mode_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) dut1 (
      .clk(clk), .rst(rst), .ce(ce), .mode_ld(mode_ld), .mode_in(mode_in),
      .a(a), .b(b), .err_clr(err_clr), .q(q1), .q_bar(qb1), .mode(mode1),
      .err(err1), .err_cnt(cnt1)
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      , .q_rise(rise1), .q_fall(fall1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic c, input logic ml, input logic [1:0] mi,
                        input logic [7:0] av, input logic [7:0] bv, input logic ec);
      rst = r; ce = c; mode_ld = ml; mode_in = mi; a = av; b = bv; err_clr = ec;
   endtask

   initial begin
      drive(1'b1, 1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
      tick();
      // Reset overrides everything, including the mode load.
      chk("rst_q", 32'(q0), 32'hA5);
      chk("rst_qbar", 32'(qb0), 32'h5A);
      chk("rst_mode", 32'(mode0), 32'h2);
      chk("rst_err", 32'(err0), 32'h0);
      chk("rst_cnt", 32'(cnt0), 32'h0);
      chk("rst_cnt1", 32'(cnt1), 32'h0);

      // Load SR with ce=0: q holds.
      drive(1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ld_sr_mode", 32'(mode0), 32'h0);
      chk("ld_sr_q", 32'(q0), 32'hA5);

      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h0F, 8'hF0, 1'b0);
      tick();
      chk("sr_q", 32'(q0), 32'h0F);
      chk("sr_err", 32'(err0), 32'h00);

      // Four consecutive illegal cycles.
      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h01, 8'h01, 1'b0);
      tick();
      chk("ill1_q", 32'(q0), 32'h0F);
      chk("ill1_err", 32'(err0), 32'h01);
      chk("ill1_cnt", 32'(cnt0), 32'h1);
      chk("ill1_cnt1", 32'(cnt1), 32'h1);
      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h02, 8'h02, 1'b0);
      tick();
      chk("ill2_err", 32'(err0), 32'h03);
      chk("ill2_cnt", 32'(cnt0), 32'h2);
      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h80, 8'h80, 1'b0);
      tick();
      chk("ill3_err", 32'(err0), 32'h83);
      chk("ill3_cnt1", 32'(cnt1), 32'h3);
      tick();
      chk("ill4_cnt", 32'(cnt0), 32'h4);
      chk("ill4_cnt1_sat", 32'(cnt1), 32'h3);
      chk("ill4_q", 32'(q0), 32'h0F);

      // ce=0: no illegal event, everything holds.
      drive(1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0);
      tick();
      chk("ce0_err", 32'(err0), 32'h83);
      chk("ce0_cnt", 32'(cnt0), 32'h4);
      chk("ce0_q", 32'(q0), 32'h0F);

      // Clear together with a new illegal event: set wins.
      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h10, 8'h10, 1'b1);
      tick();
      chk("clrset_err", 32'(err0), 32'h10);
      chk("clrset_cnt", 32'(cnt0), 32'h1);
      chk("clrset_cnt1", 32'(cnt1), 32'h1);
      chk("clrset_q", 32'(q0), 32'h0F);

      drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
      tick();
      chk("clr_err", 32'(err0), 32'h00);
      chk("clr_cnt", 32'(cnt0), 32'h0);
      chk("clr_cnt1", 32'(cnt1), 32'h0);

      // JK toggle.
      drive(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ld_jk_mode", 32'(mode0), 32'h1);
      drive(1'b0, 1'b1, 1'b0, 2'b01, 8'hFF, 8'hFF, 1'b0);
      tick();
      chk("jk_t1_q", 32'(q0), 32'hF0);
      chk("jk_t1_err", 32'(err0), 32'h00);
      tick();
      chk("jk_t2_q", 32'(q0), 32'h0F);
      chk("jk_t2_cnt", 32'(cnt0), 32'h0);

      // Load T while JK holds this cycle.
      drive(1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ld_t_mode", 32'(mode0), 32'h3);
      chk("ld_t_q", 32'(q0), 32'h0F);
      drive(1'b0, 1'b1, 1'b0, 2'b11, 8'h81, 8'hFF, 1'b0);
      tick();
      chk("t_q", 32'(q0), 32'h8E);
      chk("t_err", 32'(err0), 32'h00);

      // Back to D, then load T in the same cycle as a D update.
      drive(1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ld_d_mode", 32'(mode0), 32'h2);
      chk("ld_d_q", 32'(q0), 32'h8E);
      drive(1'b0, 1'b1, 1'b1, 2'b11, 8'h3C, 8'h00, 1'b0);
      tick();
      chk("oldmode_q", 32'(q0), 32'h3C);
      chk("oldmode_mode", 32'(mode0), 32'h3);
      drive(1'b0, 1'b0, 1'b0, 2'b11, 8'hFF, 8'h00, 1'b0);
      tick();
      chk("ce0_hold_q", 32'(q0), 32'h3C);
      chk("ce0_hold_qbar", 32'(qb0), 32'hC3);
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("edge_rise_8e_3c", 32'(rise0), 32'h30);
      chk("edge_fall_8e_3c", 32'(fall0), 32'h82);
`endif

      // T mode: toggle bit2 down then back up.
      drive(1'b0, 1'b1, 1'b0, 2'b11, 8'h04, 8'h00, 1'b0);
      tick();
      chk("t_b2_dn_q", 32'(q0), 32'h38);
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("edge_quiet_rise", 32'(rise0), 32'h00);
      chk("edge_quiet_fall", 32'(fall0), 32'h00);
`endif
      tick();
      chk("t_b2_up_q", 32'(q0), 32'h3C);
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("edge_b2_fall", 32'(fall0), 32'h04);
      chk("edge_b2_fall_rise", 32'(rise0), 32'h00);
`endif
      drive(1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0);
      tick();
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("edge_b2_rise", 32'(rise0), 32'h04);
      chk("edge_b2_rise_fall", 32'(fall0), 32'h00);
`endif
      tick();
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("edge_b2_rise_end", 32'(rise0), 32'h00);
`endif
      chk("hold_q", 32'(q0), 32'h3C);

      // Reset mid-operation with a pending mode load.
      drive(1'b1, 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0);
      tick();
      chk("rst2_q", 32'(q0), 32'hA5);
      chk("rst2_mode", 32'(mode0), 32'h2);
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("rst2_rise", 32'(rise0), 32'h00);
      chk("rst2_fall", 32'(fall0), 32'h00);
`endif
      drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      tick();
      chk("post_rst_mode", 32'(mode0), 32'h2);
      chk("post_rst_q", 32'(q0), 32'hA5);
`ifdef MULTI_MODE_FF_BANK_EDGE_DET_EN
      chk("post_rst_rise", 32'(rise0), 32'h00);
      chk("post_rst_fall", 32'(fall0), 32'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
